pushbutton_debouncer: RTL and testbench

Debounces a noisy mechanical pushbutton input and produces a clean level plus a press-toggled state bit. Sits between a board-level button pin and control logic that needs one clean event per physical press, e.g. a mode/LED toggle. Supports clock-gated operation so it can share a gated clock domain with other datapath blocks.

---
 rtl/pushbutton_debouncer.sv | 64 ++++++
 tb/tb_pushbutton_debouncer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_debouncer.sv
// Pushbutton debouncer: produces a clean button level and a bit that toggles once per press.
// Define PUSHBUTTON_SYNC_EN to add a 2-flop synchronizer for asynchronous button pins.
module pushbutton_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cg,
  input  logic i_button,
  output logic o_debounced,
  output logic o_toggle
);

  localparam int unsigned CNT_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
      $error("pushbutton_debouncer: DEBOUNCE_CYCLES must be in 1..65535");
    end
  endgenerate

  logic             s;
  logic [CNT_W-1:0] cnt;

`ifdef PUSHBUTTON_SYNC_EN
  logic [1:0] sync_q;

  // The synchronizer is gated like everything else, so gated cycles add no samples.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q <= '0;
    end else if (i_cg) begin
      sync_q <= {sync_q[0], i_button};
    end
  end

  assign s = sync_q[1];
`else
  assign s = i_button;
`endif

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
  // comparison against o_debounced below always sees last cycle's level.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt         <= '0;
      o_debounced <= 1'b0;
      o_toggle    <= 1'b0;
    end else if (i_cg) begin
      if (s == o_debounced) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt         <= '0;
        o_debounced <= s;
        // Only a debounced press flips the toggle; a release leaves it alone.
        if (s) o_toggle <= ~o_toggle;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pushbutton_debouncer.sv
// Self-checking bench: three debouncers (7, 8, 9 cycles) share one stimulus and are compared
// every cycle against a sample-window model, plus directed checks on the 8-cycle instance.
module tb_pushbutton_debouncer;

`ifdef PUSHBUTTON_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int L8 = 8 + SYNC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cg = 1'b1;
  logic button = 1'b0;
  logic deb [3];
  logic tog [3];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pushbutton_debouncer #(.DEBOUNCE_CYCLES(7)) u_d7 (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_button(button),
    .o_debounced(deb[0]), .o_toggle(tog[0]));
  pushbutton_debouncer #(.DEBOUNCE_CYCLES(8)) u_d8 (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_button(button),
    .o_debounced(deb[1]), .o_toggle(tog[1]));
  pushbutton_debouncer #(.DEBOUNCE_CYCLES(9)) u_d9 (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_button(button),
    .o_debounced(deb[2]), .o_toggle(tog[2]));

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  // Model: the level flips once the last D enabled samples all disagree with it.
  int          dcyc [3] = '{7, 8, 9};
  logic [15:0] win  [3];
  logic        m_deb [3];
  logic        m_tog [3];
  logic        m_s1, m_s2;

  always @(posedge clk or negedge rst) begin
    logic s;
    logic [15:0] mask;
    if (!rst) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      for (int k = 0; k < 3; k++) begin
        win[k] = '0; m_deb[k] = 1'b0; m_tog[k] = 1'b0;
      end
    end else if (cg) begin
      s = (SYNC == 2) ? m_s2 : button;
      m_s2 = m_s1;
      m_s1 = button;
      for (int k = 0; k < 3; k++) begin
        mask = 16'((32'd1 << dcyc[k]) - 1);
        win[k] = {win[k][14:0], s};
        if ((win[k] & mask) == (m_deb[k] ? 16'd0 : mask)) begin
          m_deb[k] = ~m_deb[k];
          if (m_deb[k]) m_tog[k] = ~m_tog[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model_deb[%0d]", k), deb[k], m_deb[k]);
      check($sformatf("model_tog[%0d]", k), tog[k], m_tog[k]);
    end
  end

  // Toggle flips vs. rising debounced edges, counted during the PWM sweep.
  bit   count_en = 1'b0;
  int   rises [3] = '{0, 0, 0};
  int   flips [3] = '{0, 0, 0};
  logic pdeb [3] = '{1'b0, 1'b0, 1'b0};
  logic ptog [3] = '{1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (count_en) begin
        if (deb[k] && !pdeb[k]) rises[k]++;
        if (tog[k] != ptog[k]) flips[k]++;
      end
      pdeb[k] = deb[k];
      ptog[k] = tog[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle(input int n);
    button = 1'b0;
    cg = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    // Reset held: outputs stay 0.
    rst = 1'b0; cg = 1'b1; button = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("reset_deb", deb[1], 1'b0);
      check("reset_tog", tog[1], 1'b0);
    end
    rst = 1'b1;

    // Clean press: rises exactly L8 edges after the button goes high.
    button = 1'b1;
    for (int e = 1; e <= L8 + 2; e++) begin
      tick();
      check($sformatf("press_deb_e%0d", e), deb[1], (e >= L8));
      check($sformatf("press_tog_e%0d", e), tog[1], (e >= L8));
    end

    // Release: falls L8 edges later, toggle stays 1.
    button = 1'b0;
    for (int e = 1; e <= L8 + 2; e++) begin
      tick();
      check($sformatf("release_deb_e%0d", e), deb[1], (e < L8));
      check($sformatf("release_tog_e%0d", e), tog[1], 1'b1);
    end

    // Second press returns toggle to 0.
    button = 1'b1;
    repeat (L8) tick();
    check("press2_deb", deb[1], 1'b1);
    check("press2_tog", tog[1], 1'b0);
    settle(L8 + 2);
    check("press2_release_deb", deb[1], 1'b0);

    // Bounce: 7-high / 1-low train never propagates for D=8.
    for (int p = 0; p < 5; p++) begin
      button = 1'b1;
      repeat (7) begin tick(); check("bounce_deb", deb[1], 1'b0); end
      button = 1'b0;
      tick(); check("bounce_deb", deb[1], 1'b0);
    end
    check("bounce_tog", tog[1], 1'b0);
    button = 1'b1;
    repeat (L8 - 1) tick();
    check("bounce_hold_early", deb[1], 1'b0);
    tick();
    check("bounce_hold_rise", deb[1], 1'b1);
    check("bounce_hold_tog", tog[1], 1'b1);
    settle(L8 + 2);

    // Clock gate: five gated cycles delay the rise by exactly five edges.
    button = 1'b1;
    repeat (5) tick();
    cg = 1'b0;
    repeat (5) begin tick(); check("gated_hold_deb", deb[1], 1'b0); end
    cg = 1'b1;
    repeat (L8 - 6) tick();
    check("gated_early", deb[1], 1'b0);
    tick();
    check("gated_rise", deb[1], 1'b1);
    check("gated_tog", tog[1], 1'b0);
    settle(L8 + 2);

    // Async reset at count 5 with the button held: a full latency is needed again.
    button = 1'b1;
    repeat (SYNC + 5) tick();
    rst = 1'b0;
    #1;
    check("async_rst_deb", deb[1], 1'b0);
    check("async_rst_tog", tog[1], 1'b0);
    #1 rst = 1'b1;
    for (int e = 1; e <= L8; e++) begin
      tick();
      check($sformatf("after_rst_deb_e%0d", e), deb[1], (e >= L8));
    end
    settle(L8 + 2);

    // PWM sweep: duty ramps 0..31 over 1024 cycles.
    count_en = 1'b1;
    for (int c = 0; c < 1024; c++) begin
      button = ((c % 32) < (c / 32));
      tick();
    end
    settle(14);
    count_en = 1'b0;
    for (int k = 0; k < 3; k++)
      check($sformatf("pwm_flips_eq_rises[%0d]", k), (flips[k] == rises[k]), 1'b1);
    check("pwm_saw_rises", (rises[1] > 0), 1'b1);

    // Random runs, random gating and rare async reset pulses.
    for (int c = 0; c < 3000; ) begin
      int run;
      run = $urandom_range(1, 14);
      button = $urandom_range(0, 1);
      for (int r = 0; r < run; r++) begin
        cg = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 499) == 0) begin
          rst = 1'b0;
          #2 rst = 1'b1;
        end
        tick();
        c++;
      end
    end
    settle(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
